// File: rtl/drm_bus_master_axi4st_pkg.sv
// Shared types and bit positions for the DRM bit-serial bus master over AXI4-Stream.
package drm_bus_master_pkg;

    localparam int unsigned STREAM_W = 32;

    // Outbound beat bit positions (toward the activator)
    localparam int unsigned OB_DAT    = 0;
    localparam int unsigned OB_WE     = 1;
    localparam int unsigned OB_ADR_LO = 2;
    localparam int unsigned OB_ADR_HI = 3;
    localparam int unsigned OB_CYC    = 4;
    localparam int unsigned OB_CS     = 5;

    // Inbound beat bit positions (from the activator)
    localparam int unsigned IB_DAT    = 0;
    localparam int unsigned IB_STA    = 1;
    localparam int unsigned IB_INTR   = 2;
    localparam int unsigned IB_ACK    = 3;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        WAIT_ACK = 3'd2,
        RECV     = 3'd3,
        DONE     = 3'd4
    } state_e;

    // Assemble one outbound beat; unused upper bits are always zero
    function automatic logic [STREAM_W-1:0] make_beat(
        input logic       cs,
        input logic       cyc,
        input logic [1:0] adr,
        input logic       we,
        input logic       dat
    );
        logic [STREAM_W-1:0] b;
        b                       = '0;
        b[OB_CS]                = cs;
        b[OB_CYC]               = cyc;
        b[OB_ADR_HI:OB_ADR_LO]  = adr;
        b[OB_WE]                = we;
        b[OB_DAT]               = dat;
        return b;
    endfunction

endpackage

// File: rtl/drm_bus_master_axi4st_if.sv
// Command/response handshake plus the two AXI4-Stream directions of the bus master.
interface drm_bus_master_axi4st_if #(
    parameter int unsigned DATA_W = 32
);
    import drm_bus_master_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_we;
    logic [1:0]          cmd_adr;
    logic [DATA_W-1:0]   cmd_wdata;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                rsp_sta;
    logic                rsp_timeout;

    logic                intr;

    logic [STREAM_W-1:0] m_tdata;
    logic                m_tvalid;
    logic                m_tready;

    logic [STREAM_W-1:0] s_tdata;
    logic                s_tvalid;
    logic                s_tready;

    // Bus master side
    modport master (
        input  cmd_valid, cmd_we, cmd_adr, cmd_wdata, rsp_ready,
        input  m_tready, s_tdata, s_tvalid,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_sta, rsp_timeout, intr,
        output m_tdata, m_tvalid, s_tready
    );

    // Controller / activator side
    modport slave (
        output cmd_valid, cmd_we, cmd_adr, cmd_wdata, rsp_ready,
        output m_tready, s_tdata, s_tvalid,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_sta, rsp_timeout, intr,
        input  m_tdata, m_tvalid, s_tready
    );

endinterface

// File: rtl/drm_bus_master_axi4st_serdes.sv
// Write-data serialiser, read-data deserialiser and shared bit counter.
module drm_bus_bit_serdes #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_tx_shift,
    input  logic              i_rx_first,
    input  logic              i_rx_shift,
    input  logic              i_rx_bit,
    output logic              o_tx_dat_nxt,
    output logic              o_last,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] r_tx;
    logic [DATA_W-1:0] r_rx;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_tx_bit1;
    logic [DATA_W-1:0] w_rx_shifted;

    // Bit 1 of the TX register and the RX shift-in value, safe for a 1-bit word
    generate
        if (DATA_W > 1) begin : g_wide
            assign w_tx_bit1    = r_tx[1];
            assign w_rx_shifted = {i_rx_bit, r_rx[DATA_W-1:1]};
        end else begin : g_narrow
            assign w_tx_bit1    = 1'b0;
            assign w_rx_shifted = i_rx_bit;
        end
    endgenerate

    // Load on command accept, shift LSB-first on accepted TX beats and valid RX beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx  <= '0;
            r_rx  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_tx  <= i_wdata;
            r_rx  <= '0;
            r_cnt <= '0;
        end else if (i_tx_shift) begin
            r_tx  <= r_tx >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_rx_first) begin
            r_rx  <= w_rx_shifted;
            r_cnt <= CNT_W'(1);
        end else if (i_rx_shift) begin
            r_rx  <= w_rx_shifted;
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // DAT for the beat that will be on the bus next cycle
    assign o_tx_dat_nxt = i_load     ? i_wdata[0] :
                          i_tx_shift ? w_tx_bit1  : r_tx[0];
    assign o_last       = (r_cnt == CNT_W'(DATA_W - 1));
    assign o_rdata      = r_rx;

endmodule

// File: rtl/drm_bus_master_axi4st.sv
// DRM bit-serial register bus master: one command at a time over AXI4-Stream.
module drm_bus_master_axi4st
    import drm_bus_master_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                    drm_aclk,
    input  logic                    drm_arstn,
    drm_bus_master_axi4st_if.master bus
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    state_e              r_state;
    state_e              w_state_nxt;

    logic                r_m_tvalid;
    logic [STREAM_W-1:0] r_m_tdata;
    logic                r_cmd_ready;
    logic                r_rsp_valid;
    logic                r_rsp_sta;
    logic                r_rsp_timeout;
    logic                r_intr;
    logic                r_we;
    logic [1:0]          r_adr;
    logic [TO_W-1:0]     r_to_cnt;

    logic                w_cmd_acc;
    logic                w_beat_acc;
    logic                w_ack;
    logic [TO_W-1:0]     w_to_inc;
    logic                w_load;
    logic                w_tx_shift;
    logic                w_rx_first;
    logic                w_rx_shift;
    logic                w_sta_set;
    logic                w_to_set;
    logic                w_rsp_set;
    logic                w_rsp_valid_nxt;
    logic                w_we_nxt;
    logic [1:0]          w_adr_nxt;
    logic [STREAM_W-1:0] w_beat_nxt;
    logic                w_tx_dat_nxt;
    logic                w_last;
    logic [DATA_W-1:0]   w_rdata;
    logic                w_unused_tdata;

    assign w_cmd_acc      = bus.cmd_valid && r_cmd_ready;
    assign w_beat_acc     = r_m_tvalid && bus.m_tready;
    assign w_ack          = bus.s_tvalid && bus.s_tdata[IB_ACK];
    assign w_to_inc       = r_to_cnt + TO_W'(1);
    assign w_unused_tdata = ^bus.s_tdata[STREAM_W-1:IB_ACK+1];

    drm_bus_bit_serdes #(
        .DATA_W (DATA_W)
    ) u_serdes (
        .clk          (drm_aclk),
        .rst_n        (drm_arstn),
        .i_load       (w_load),
        .i_wdata      (bus.cmd_wdata),
        .i_tx_shift   (w_tx_shift),
        .i_rx_first   (w_rx_first),
        .i_rx_shift   (w_rx_shift),
        .i_rx_bit     (bus.s_tdata[IB_DAT]),
        .o_tx_dat_nxt (w_tx_dat_nxt),
        .o_last       (w_last),
        .o_rdata      (w_rdata)
    );

    // State register
    always_ff @(posedge drm_aclk or negedge drm_arstn) begin
        if (!drm_arstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and per-cycle datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_tx_shift  = 1'b0;
        w_rx_first  = 1'b0;
        w_rx_shift  = 1'b0;
        w_sta_set   = 1'b0;
        w_to_set    = 1'b0;
        w_rsp_set   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_cmd_acc) begin
                    w_load      = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                if (w_beat_acc) begin
                    w_tx_shift = 1'b1;
                    if (w_last) begin
                        w_state_nxt = WAIT_ACK;
                    end
                end
            end
            WAIT_ACK: begin
                // ACK beats the timeout when both land on the same cycle
                if (w_ack) begin
                    w_sta_set = 1'b1;
                    if (r_we) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_rx_first = 1'b1;
                        if (DATA_W > 1) begin
                            w_state_nxt = RECV;
                        end else begin
                            w_state_nxt = DONE;
                        end
                    end
                end else if (w_to_inc == TO_W'(TIMEOUT_CYC)) begin
                    w_to_set    = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            RECV: begin
                if (bus.s_tvalid) begin
                    w_rx_shift = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (w_beat_acc) begin
                    w_rsp_set   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_we_nxt        = w_load ? bus.cmd_we  : r_we;
    assign w_adr_nxt       = w_load ? bus.cmd_adr : r_adr;
    assign w_rsp_valid_nxt = w_rsp_set ? 1'b1 :
                             (r_rsp_valid && bus.rsp_ready) ? 1'b0 : r_rsp_valid;

    // Outbound beat for the state entered next cycle
    always_comb begin
        w_beat_nxt = '0;
        case (w_state_nxt)
            SEND:           w_beat_nxt = make_beat(1'b1, 1'b1, w_adr_nxt, w_we_nxt,
                                                   w_we_nxt & w_tx_dat_nxt);
            WAIT_ACK, RECV: w_beat_nxt = make_beat(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
            default:        w_beat_nxt = '0;
        endcase
    end

    // Registered outputs, command latch, response flags and timeout counter
    always_ff @(posedge drm_aclk or negedge drm_arstn) begin
        if (!drm_arstn) begin
            r_m_tvalid    <= 1'b0;
            r_m_tdata     <= '0;
            r_cmd_ready   <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_sta     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_intr        <= 1'b0;
            r_we          <= 1'b0;
            r_adr         <= '0;
            r_to_cnt      <= '0;
        end else begin
            r_m_tvalid  <= 1'b1;
            r_m_tdata   <= w_beat_nxt;
            r_cmd_ready <= (w_state_nxt == IDLE) && !w_rsp_valid_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_we        <= w_we_nxt;
            r_adr       <= w_adr_nxt;
            r_to_cnt    <= (r_state == WAIT_ACK) ? w_to_inc : '0;
            if (w_load) begin
                r_rsp_sta     <= 1'b0;
                r_rsp_timeout <= 1'b0;
            end else begin
                if (w_sta_set) begin
                    r_rsp_sta <= bus.s_tdata[IB_STA];
                end
                if (w_to_set) begin
                    r_rsp_timeout <= 1'b1;
                end
            end
            if (bus.s_tvalid) begin
                r_intr <= bus.s_tdata[IB_INTR];
            end
        end
    end

    assign bus.cmd_ready   = r_cmd_ready;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = w_rdata;
    assign bus.rsp_sta     = r_rsp_sta;
    assign bus.rsp_timeout = r_rsp_timeout;
    assign bus.intr        = r_intr;
    assign bus.m_tdata     = r_m_tdata;
    assign bus.m_tvalid    = r_m_tvalid;
    assign bus.s_tready    = 1'b1;

endmodule

// File: tb/tb_drm_bus_master_axi4st.sv
// Directed + randomized bench with an activator model for drm_bus_master_axi4st.
module tb_drm_bus_master_axi4st;
    import drm_bus_master_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;
    logic intr_exp;

    always #5 clk = ~clk;

    drm_bus_master_axi4st_if #(.DATA_W(DW)) ifc ();

    drm_bus_master_axi4st #(
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .drm_aclk  (clk),
        .drm_arstn (rst_n),
        .bus       (ifc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected outbound SEND beat i: CS, CYC, ADR, WE, and the LSB-first write bit
    function automatic logic [31:0] exp_send_beat(input logic we, input logic [1:0] adr,
                                                  input logic [31:0] wdata, input int i);
        int unsigned v;
        v = 32 + 16 + 4 * int'(adr) + 2 * int'(we);
        if (we) v = v + ((wdata >> i) & 32'd1);
        return 32'(v);
    endfunction

    // Drive the inbound stream; an accepted beat sets the next expected intr
    task automatic drive_s(input logic v, input logic [3:0] nib);
        ifc.s_tvalid = v;
        ifc.s_tdata  = {28'($urandom()), nib};
        if (v) intr_exp = nib[2];
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_m_tvalid"},    32'(ifc.m_tvalid),    32'd0);
        chk({tag, "_m_tdata"},     ifc.m_tdata,          32'd0);
        chk({tag, "_cmd_ready"},   32'(ifc.cmd_ready),   32'd0);
        chk({tag, "_rsp_valid"},   32'(ifc.rsp_valid),   32'd0);
        chk({tag, "_rsp_rdata"},   ifc.rsp_rdata,        32'd0);
        chk({tag, "_rsp_sta"},     32'(ifc.rsp_sta),     32'd0);
        chk({tag, "_rsp_timeout"}, 32'(ifc.rsp_timeout), 32'd0);
        chk({tag, "_intr"},        32'(ifc.intr),        32'd0);
        chk({tag, "_s_tready"},    32'(ifc.s_tready),    32'd1);
    endtask

    // One command through the activator model. ack_dly: WAIT cycle carrying ACK (0 = never).
    // rdy_mode: 0 always ready, 1 toggling 1,0,1,0, 2 random. abort_at: SEND bit to reset on (-1 none).
    task automatic run_txn(input logic we, input logic [1:0] adr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input logic sta, input int ack_dly,
                           input int rdy_mode, input int abort_at);
        int       sent, waitc, rx_i, phase, n, stall;
        bit       fin, rdy, timed_out, ack_given;
        logic     sv;
        logic [3:0]  snib;
        logic [31:0] beat, exp_rd;
        ifc.cmd_we    = we;
        ifc.cmd_adr   = adr;
        ifc.cmd_wdata = we ? wdata : 32'($urandom());
        ifc.cmd_valid = 1'b1;
        n = 0;
        while (ifc.cmd_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_seen", 32'(ifc.cmd_ready), 32'd1);
        @(negedge clk);
        ifc.cmd_valid = 1'b0;
        ifc.cmd_wdata = 32'($urandom());
        sent = 0; waitc = 0; rx_i = 1; phase = 0; fin = 0;
        timed_out = 0; ack_given = 0; stall = $urandom_range(0, 2);
        for (int cyc = 0; cyc < 600 && !fin; cyc++) begin
            if (cyc > 0) @(negedge clk);
            case (rdy_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ifc.m_tready = rdy;
            beat = ifc.m_tdata;
            sv   = 1'b0;
            snib = 4'h0;
            case (phase)
                0: begin
                    if (sent == abort_at) begin
                        drive_s(1'b0, 4'h0);
                        rst_n = 1'b0;
                        #1;
                        check_reset_values("abort");
                        intr_exp = 1'b0;
                        @(negedge clk);
                        rst_n = 1'b1;
                        for (int k = 0; k < 40; k++) begin
                            @(negedge clk);
                            chk("abort_no_rsp", 32'(ifc.rsp_valid), 32'd0);
                        end
                        chk("abort_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
                        chk("abort_idle_beat", ifc.m_tdata, 32'd0);
                        fin = 1;
                    end else begin
                        chk("send_tvalid", 32'(ifc.m_tvalid), 32'd1);
                        chk($sformatf("send_beat%0d", sent), beat,
                            exp_send_beat(we, adr, wdata, sent));
                        // Spurious ACK beats while sending must be ignored
                        if ($urandom_range(0, 3) == 0) begin
                            sv = 1'b1;
                            snib = {1'b1, 3'($urandom())};
                        end
                        if (rdy) begin
                            sent++;
                            if (sent == DW) phase = 1;
                        end
                    end
                end
                1: begin
                    waitc++;
                    chk("wait_beat", beat, 32'h30);
                    chk("wait_intr", 32'(ifc.intr), 32'(intr_exp));
                    if (ack_dly > 0 && waitc == ack_dly) begin
                        sv = 1'b1;
                        snib = {1'b1, 1'($urandom()), sta, rdata[0]};
                        ack_given = 1;
                        phase = (we || DW == 1) ? 3 : 2;
                    end else begin
                        sv = 1'($urandom_range(0, 1));
                        snib = {1'b0, 3'($urandom())};
                        if (waitc == TO) begin
                            timed_out = 1;
                            phase = 3;
                        end
                    end
                end
                2: begin
                    chk("recv_beat", beat, 32'h30);
                    if ($urandom_range(0, 2) != 0) begin
                        sv = 1'b1;
                        snib = {1'b0, 1'($urandom()), 1'($urandom()), rdata[rx_i]};
                        rx_i++;
                        if (rx_i == DW) phase = 3;
                    end
                end
                3: begin
                    chk("done_beat", beat, 32'd0);
                    chk("done_no_rsp", 32'(ifc.rsp_valid), 32'd0);
                    if (rdy) phase = 4;
                end
                4: begin
                    exp_rd = (we || timed_out) ? 32'd0 : rdata;
                    chk("rsp_valid", 32'(ifc.rsp_valid), 32'd1);
                    chk("rsp_rdata", ifc.rsp_rdata, exp_rd);
                    chk("rsp_sta", 32'(ifc.rsp_sta), timed_out ? 32'd0 : 32'(sta));
                    chk("rsp_timeout", 32'(ifc.rsp_timeout), 32'(timed_out));
                    chk("rsp_cmd_ready_low", 32'(ifc.cmd_ready), 32'd0);
                    // A pending command must not be taken while the response is held
                    ifc.cmd_valid = 1'b1;
                    if (stall == 0) begin
                        ifc.rsp_ready = 1'b1;
                        phase = 5;
                    end else begin
                        stall--;
                    end
                end
                default: begin
                    ifc.cmd_valid = 1'b0;
                    ifc.rsp_ready = 1'b0;
                    chk("rsp_released", 32'(ifc.rsp_valid), 32'd0);
                    chk("cmd_ready_back", 32'(ifc.cmd_ready), 32'd1);
                    chk("wait_cycles", 32'(waitc), ack_given ? 32'(ack_dly) : 32'(TO));
                    fin = 1;
                end
            endcase
            if (rst_n) drive_s(sv, snib);
        end
        chk("txn_complete", 32'(fin), 32'd1);
        drive_s(1'b0, 4'h0);
        ifc.cmd_valid = 1'b0;
        ifc.rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] wd, rd;
        int          ad;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_we    = 1'b0;
        ifc.cmd_adr   = 2'b00;
        ifc.cmd_wdata = '0;
        ifc.rsp_ready = 1'b0;
        ifc.m_tready  = 1'b1;
        ifc.s_tvalid  = 1'b0;
        ifc.s_tdata   = '0;
        intr_exp      = 1'b0;
        rst_n         = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
        chk("post_reset_m_tvalid", 32'(ifc.m_tvalid), 32'd1);
        chk("post_reset_idle_beat", ifc.m_tdata, 32'd0);

        // INTR follows s_tdata[2] with one cycle of latency while idle
        for (int i = 0; i < 6; i++) begin
            chk("intr_idle_before", 32'(ifc.intr), 32'(intr_exp));
            drive_s(1'b1, {1'b0, (i % 2 == 0), 2'b00});
            @(negedge clk);
            chk("intr_idle_after", 32'(ifc.intr), 32'(intr_exp));
        end
        drive_s(1'b0, 4'h0);

        // Write adr 2, ACK three cycles after the last bit with STA=1
        run_txn(1'b1, 2'd2, 32'hA5A51234, 32'd0, 1'b1, 3, 0, -1);
        // Read adr 1 returning 0xFF
        run_txn(1'b0, 2'd1, 32'd0, 32'h000000FF, 1'b0, 2, 0, -1);
        // No ACK: write and read time out after exactly TO wait cycles
        run_txn(1'b1, 2'd3, 32'h0F0F_1234, 32'd0, 1'b1, 0, 0, -1);
        run_txn(1'b0, 2'd0, 32'd0, 32'hDEADBEEF, 1'b1, 0, 2, -1);
        // ACK on the very cycle the timeout would fire wins
        run_txn(1'b1, 2'd1, 32'h8000_0001, 32'd0, 1'b1, TO, 0, -1);
        run_txn(1'b0, 2'd2, 32'd0, 32'h1357_9BDF, 1'b1, TO, 0, -1);
        // Ready toggling 1,0,1,0 during a write
        run_txn(1'b1, 2'd0, 32'($urandom()), 32'd0, 1'b0, 1, 1, -1);
        // Reset during SEND bit 10, then a normal read
        run_txn(1'b1, 2'd2, 32'($urandom()), 32'd0, 1'b1, 3, 0, 10);
        run_txn(1'b0, 2'd3, 32'd0, 32'($urandom()), 1'b1, 4, 0, -1);

        // Randomized commands
        for (int t = 0; t < 8; t++) begin
            wd = 32'($urandom());
            rd = 32'($urandom());
            ad = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO));
            run_txn(1'($urandom()), 2'($urandom()), wd, rd, 1'($urandom()), ad, 2, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/drm_bus_master_axi4st.md
# drm_bus_master_axi4st

Controller-side master for the DRM bit-serial register bus carried over AXI4-Stream. It accepts one register command at a time, serialises it into 32-bit stream beats toward an IP activator, and collects the activator's ACK, status and serial read data from the return stream. It also forwards the activator interrupt. It sits in the DRM controller clock domain, directly facing the activator's AXI4-ST wrapper.

## Interface
- `DATA_W`, default 32: register word width in bits, legal range 1..32; bits are serialised LSB first.
- `TIMEOUT_CYC`, default 1024: number of WAIT_ACK cycles allowed before a timeout is declared; must be ≥ 1.
- `drm_aclk` in 1: the single clock.
- `drm_arstn` in 1: asynchronous active-low reset.
- `cmd_valid` in 1, `cmd_ready` out 1: command handshake.
- `cmd_we` in 1: 1 = write, 0 = read.
- `cmd_adr` in 2: register address.
- `cmd_wdata` in DATA_W: write data; ignored for reads.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_rdata` out DATA_W: read data; 0 for writes and timeouts.
- `rsp_sta` out 1: STA bit sampled on the ACK beat.
- `rsp_timeout` out 1: set when no ACK arrived within `TIMEOUT_CYC`.
- `intr` out 1: registered copy of the activator INTR bit.
- `m_tdata` out 32, `m_tvalid` out 1, `m_tready` in 1: stream toward the activator.
- `s_tdata` in 32, `s_tvalid` in 1, `s_tready` out 1: stream from the activator.

## Operation
- Outbound beat layout in `m_tdata`:
  - [5] CS, [4] CYC, [3:2] ADR, [1] WE, [0] DAT.
  - [31:6] are always 0.
- Inbound beat layout in `s_tdata`:
  - [3] ACK, [2] INTR, [1] STA, [0] DAT.
  - [31:4] are ignored.
- Stream control:
  - `s_tready` is constant 1.
  - After reset, `m_tvalid` is 1 on every cycle.
  - An idle beat has all bits 0.
- `cmd_ready` = (state == IDLE) && !`rsp_valid`.
- IDLE:
  - Drive idle beats.
  - On command accept, latch we, adr and wdata; clear the bit counter; go to SEND.
- SEND:
  - Drive CS=1, CYC=1, latched ADR and WE.
  - DAT = wdata[bit] for writes, 0 for reads.
  - The bit counter advances only on a beat where `m_tvalid`·`m_tready`.
  - After beat DATA_W−1 is accepted, go to WAIT_ACK.
  - ACK seen during SEND is ignored.
- WAIT_ACK:
  - Drive CS=1, CYC=1, DAT=0.
  - The timeout counter increments every cycle.
  - On `s_tvalid`·ACK, capture STA.
  - A read also captures `s_tdata`[0] as rdata[0] and goes to RECV when DATA_W > 1; otherwise it goes to DONE.
  - A write goes to DONE.
  - When the counter reaches TIMEOUT_CYC with no ACK: `rsp_timeout`=1, `rsp_rdata`=0, `rsp_sta`=0, go to DONE.
  - ACK arriving on the same cycle the counter reaches TIMEOUT_CYC wins; that case is not a timeout.
- RECV:
  - CS=1, CYC=1 are held.
  - On each `s_tvalid` beat, shift `s_tdata`[0] into rdata bits 1..DATA_W−1 in order.
  - After the last bit, go to DONE.
- DONE:
  - Drive one idle beat; it must be accepted by `m_tready`.
  - Set `rsp_valid`; go to IDLE.
- Response handling:
  - `rsp_*` are held stable until `rsp_valid`·`rsp_ready`.
  - The next command cannot be accepted before that.
- `intr` <= `s_tdata`[2] on every `s_tvalid` cycle, independent of state.

## Timing
- Reset values:
  - `m_tvalid`=0, `m_tdata`=0, `cmd_ready`=0 during reset.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_sta`=0, `rsp_timeout`=0, `intr`=0.
  - `s_tready`=1.
- `cmd_ready` rises in the first cycle after reset deassertion.
- Reset asserted mid-transaction:
  - Outputs go to their reset values immediately.
  - The command is abandoned and no response is produced.
- The first SEND beat is on `m_tdata` in the cycle after command accept.
- Write with `m_tready`=1 throughout: DATA_W beats, then at least 1 WAIT_ACK cycle, then the DONE beat. `rsp_valid` rises in the cycle after the DONE beat is accepted.
- Read adds DATA_W−1 RECV beats after the ACK beat.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- `drm_bus_master_pkg` holds:
  - the state enum {IDLE, SEND, WAIT_ACK, RECV, DONE};
  - the outbound bit-index constants (CS, CYC, ADR_LO/HI, WE, DAT);
  - the inbound bit-index constants (ACK, INTR, STA, DAT).
- One sub-module, `drm_bus_bit_serdes`, holds:
  - the DATA_W shift registers;
  - the bit counter with a last-bit flag.
- The FSM, timeout counter and handshakes live in the top module.

## Test plan
- Write to adr 2 with wdata 0xA5A51234, `m_tready`=1; the model ACKs 3 cycles after the last bit with STA=1:
  - 32 beats with CS=1, CYC=1, WE=1, ADR=2, DAT carrying the LSB-first bits of 0xA5A51234;
  - then `rsp_sta`=1, `rsp_timeout`=0, `rsp_rdata`=0.
- Read from adr 1; the model returns 0x000000FF starting at the ACK beat:
  - `rsp_rdata`=0x000000FF;
  - every outbound SEND beat has DAT=0 and WE=0.
- No ACK with TIMEOUT_CYC=16:
  - `rsp_valid` with `rsp_timeout`=1, `rsp_rdata`=0;
  - exactly 16 WAIT_ACK cycles are observed.
- `m_tready` toggled 1,0,1,0 during a write:
  - the bit counter advances only on accepted beats;
  - the DAT sequence is unchanged and complete.
- `drm_arstn` pulsed during SEND bit 10:
  - all outputs return to their reset values;
  - no response is produced;
  - a following read completes normally.
- INTR toggled on `s_tdata`[2] while IDLE and while in WAIT_ACK: `intr` follows with exactly 1 cycle of latency.
